ps2_key_sequencer: RTL and testbench
====================================

# ps2_key_sequencer

Consumes raw PS/2 scan-code bytes from the keyboard receiver FIFO, strips the `F0` (break) and `E0` (extended) prefixes, and drives the scan-code-to-ASCII lookup table. It emits one registered key event per complete code sequence and tracks the shift state and the currently held key. It keeps a key-press counter for the 7-segment display path. It sits between the PS/2 receiver and the display/text-buffer logic.

## Interface
- `CNT_W`, default 8: width of the press counter.

- `clk`  in  1  system clock.
- `clrn`  in  1  reset; one clock, reset asynchronous, active-low.
- `rx_data`  in  8  receiver FIFO head byte.
- `rx_ready`  in  1  FIFO non-empty.
- `rx_next_n`  out  1  active-low pop strobe, one cycle per consumed byte.
- `lk_scan`  out  8  scan code presented to the lookup table (registered).
- `lk_ascii`  in  8  combinational lookup result (0 = unmapped).
- `evt_valid`  out  1  one-cycle event strobe.
- `evt_scan`  out  8  event scan code (prefixes removed).
- `evt_ascii`  out  8  case-adjusted ASCII.
- `evt_make`  out  1  1 = make, 0 = break.
- `evt_ext`  out  1  sequence carried an `E0` prefix.
- `evt_repeat`  out  1  make of the already-held key (typematic).
- `held_valid`  out  1  a key is held.
- `held_scan`, `held_ascii`  out  8 each  held key, 0 when none.
- `shift`  out  1  left (`12`) or right (`59`) shift held.
- `press_cnt`  out  CNT_W  count of new presses.

## Operation
- State machine: `IDLE` -> `CLASSIFY` -> `IDLE`.
  - `IDLE`: on `rx_ready`=1, latch `rx_data` into `lk_scan`, go to `CLASSIFY`.
  - `CLASSIFY`:
    - `rx_next_n`=0 for this single cycle.
    - Byte `F0`: set `brk_pend` and return to `IDLE`; no event.
    - Byte `E0`: set `ext_pend` and return to `IDLE`; no event.
    - Any other byte: register an event from `lk_scan`/`lk_ascii`/pending flags, then clear both pending flags.
- Pending flags persist across `IDLE` waits. Sequence `E0 F0 xx` produces an event with `evt_ext`=1 and `evt_make`=0. A repeated `F0` leaves `brk_pend` set.
- Case rule:
  - If `lk_ascii` is in 65..90 and `shift`=0: `evt_ascii` = `lk_ascii` + 32.
  - Otherwise: `evt_ascii` = `lk_ascii`. This includes digits, controls and 0.
- Shift: non-extended make of `12`/`59` sets its own flag; the matching break clears it. `E0 12`/`E0 59` do not affect shift. Shift bytes still generate events.
- Held key, make events:
  - Scan and ext match the held key: `evt_repeat`=1. No count change and no held change.
  - Otherwise: `evt_repeat`=0. `press_cnt` += 1, wrapping from 2^CNT_W−1 to 0. Held ← {scan, adjusted ascii, ext}, `held_valid`=1.
- Held key, break events:
  - Matching held scan+ext: clear `held_valid`, `held_scan`, `held_ascii`.
  - Otherwise: held is unchanged.
  - `evt_repeat`=0 for all breaks.
- `held_ascii` is latched at make time. A later shift change does not update it.

## Timing
- Reset (`clrn`=0, asynchronous):
  - State `IDLE`, `rx_next_n`=1.
  - `lk_scan`, all `evt_*`, all `held_*`, `shift`, `press_cnt` = 0.
  - Pending flags cleared.
  - A reset mid-sequence (after `F0`/`E0`) discards the prefix.
- `rx_ready` sampled high at edge of cycle N: `lk_scan` valid and `rx_next_n`=0 in cycle N+1. `evt_valid`=1 and the event fields, held, shift and count updates are visible in cycle N+2.
- `rx_ready` must reflect the pop by cycle N+2. Throughput is one byte per 2 cycles.
- `evt_*` fields hold their last values between strobes. `evt_valid` is high for exactly 1 cycle.
- `lk_ascii` is sampled only in `CLASSIFY`.
- `rx_ready`=0 in `IDLE`: no pop and no state change, indefinitely.

## Test plan
- Reset, then feed `1C`: `evt_valid` at N+2 with `evt_scan`=`1C`, `evt_ascii`=97 ('a'), `evt_make`=1, `press_cnt`=1, `held_scan`=`1C`. Then feed `F0 1C`: a single break event and `held_valid`=0; the `F0` byte produces no event.
- Feed `12`, then `1C`: `shift`=1, `evt_ascii`=65. Feed `F0 12`, then `16`: `shift`=0, `evt_ascii`=49 (digit unchanged).
- Feed `1C 1C 1C` without a break: the first event has `evt_repeat`=0 and the next two have `evt_repeat`=1. `press_cnt` = 1. `rx_next_n` pulses 3 times.
- Feed `E0 12`: `evt_ext`=1 and `shift` stays 0. Feed `E0 F0 75`: break event with `evt_ext`=1.
- Drive `clrn` low after `F0` is consumed, release it, feed `1C`: a make event is produced, not a break.
- Preload the count by feeding 255 distinct press/release pairs (CNT_W=8), then one more press: `press_cnt` wraps 255→0. With `rx_ready` held high continuously, events occur every 2 cycles.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: strips F0/E0 prefixes, drives the ASCII lookup and
// emits one registered key event per complete code, tracking shift and held key.
module ps2_key_sequencer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       rx_data,
    input  logic             rx_ready,
    output logic             rx_next_n,
    output logic [7:0]       lk_scan,
    input  logic [7:0]       lk_ascii,
    output logic             evt_valid,
    output logic [7:0]       evt_scan,
    output logic [7:0]       evt_ascii,
    output logic             evt_make,
    output logic             evt_ext,
    output logic             evt_repeat,
    output logic             held_valid,
    output logic [7:0]       held_scan,
    output logic [7:0]       held_ascii,
    output logic             shift,
    output logic [CNT_W-1:0] press_cnt
);

    typedef enum logic [0:0] {StIdle, StClassify} state_e;

    state_e state_q, state_d;
    logic   brk_pend_q, ext_pend_q;
    logic   lshift_q, rshift_q;
    logic   held_ext_q;

    logic       classify, is_brk, is_ext, held_match;
    logic [7:0] adj_ascii;

    assign shift      = lshift_q | rshift_q;
    assign classify   = (state_q == StClassify);
    assign is_brk     = (lk_scan == 8'hF0);
    assign is_ext     = (lk_scan == 8'hE0);
    assign held_match = held_valid && (held_scan == lk_scan) && (held_ext_q == ext_pend_q);
    // Letters arrive upper-case from the table; fold to lower-case unless shifted.
    assign adj_ascii  = (lk_ascii >= 8'd65 && lk_ascii <= 8'd90 && !shift) ?
                        lk_ascii + 8'd32 : lk_ascii;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rx_next_n = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (rx_ready) state_d = StClassify;
            end
            StClassify: begin
                rx_next_n = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lk_scan    <= 8'h00;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            evt_valid  <= 1'b0;
            evt_scan   <= 8'h00;
            evt_ascii  <= 8'h00;
            evt_make   <= 1'b0;
            evt_ext    <= 1'b0;
            evt_repeat <= 1'b0;
            held_valid <= 1'b0;
            held_scan  <= 8'h00;
            held_ascii <= 8'h00;
            held_ext_q <= 1'b0;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            press_cnt  <= '0;
        end else begin
            evt_valid <= 1'b0;
            if (state_q == StIdle && rx_ready) lk_scan <= rx_data;
            if (classify) begin
                if (is_brk) begin
                    brk_pend_q <= 1'b1;
                end else if (is_ext) begin
                    ext_pend_q <= 1'b1;
                end else begin
                    evt_valid  <= 1'b1;
                    evt_scan   <= lk_scan;
                    evt_ascii  <= adj_ascii;
                    evt_make   <= !brk_pend_q;
                    evt_ext    <= ext_pend_q;
                    evt_repeat <= !brk_pend_q && held_match;
                    brk_pend_q <= 1'b0;
                    ext_pend_q <= 1'b0;
                    // Extended 12/59 are other keys, not shift.
                    if (!ext_pend_q) begin
                        if (lk_scan == 8'h12) lshift_q <= !brk_pend_q;
                        if (lk_scan == 8'h59) rshift_q <= !brk_pend_q;
                    end
                    if (!brk_pend_q) begin
                        if (!held_match) begin
                            press_cnt  <= press_cnt + CNT_W'(1);
                            held_valid <= 1'b1;
                            held_scan  <= lk_scan;
                            held_ascii <= adj_ascii;
                            held_ext_q <= ext_pend_q;
                        end
                    end else if (held_match) begin
                        held_valid <= 1'b0;
                        held_scan  <= 8'h00;
                        held_ascii <= 8'h00;
                        held_ext_q <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer: a byte FIFO model feeds the DUT and
// every event is logged at the falling edge for comparison with hand-computed values.
module tb_ps2_key_sequencer;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       rx_next_n;
    logic [7:0] lk_scan;
    logic [7:0] lk_ascii;
    logic       evt_valid;
    logic [7:0] evt_scan, evt_ascii;
    logic       evt_make, evt_ext, evt_repeat;
    logic       held_valid;
    logic [7:0] held_scan, held_ascii;
    logic       shift;
    logic [7:0] press_cnt;

    ps2_key_sequencer #(.CNT_W(8)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .rx_next_n  (rx_next_n),
        .lk_scan    (lk_scan),
        .lk_ascii   (lk_ascii),
        .evt_valid  (evt_valid),
        .evt_scan   (evt_scan),
        .evt_ascii  (evt_ascii),
        .evt_make   (evt_make),
        .evt_ext    (evt_ext),
        .evt_repeat (evt_repeat),
        .held_valid (held_valid),
        .held_scan  (held_scan),
        .held_ascii (held_ascii),
        .shift      (shift),
        .press_cnt  (press_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lut(input logic [7:0] s);
        case (s)
            8'h1C:   return 8'd65;
            8'h32:   return 8'd66;
            8'h16:   return 8'd49;
            default: return 8'd0;
        endcase
    endfunction

    always_comb lk_ascii = lut(lk_scan);

    typedef struct {
        logic [7:0] scan, ascii, cnt, hs, ha;
        logic       make, ext, rep, shf, hv;
        int         cyc;
    } evt_t;

    logic [7:0] fifo[$];
    evt_t       evq[$];
    int         cycle = 0;
    int         pops = 0;
    int         dbl = 0;
    logic       prev_valid = 1'b0;
    int         nchecks = 0;
    int         nerr = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Single process owns FIFO, DUT inputs and event log: everything happens at negedge.
    task automatic tick();
        evt_t e;
        @(negedge clk);
        cycle++;
        if (!rx_next_n) begin
            pops++;
            if (fifo.size() != 0) void'(fifo.pop_front());
        end
        if (evt_valid) begin
            if (prev_valid) dbl++;
            e.scan = evt_scan; e.ascii = evt_ascii; e.make = evt_make; e.ext = evt_ext;
            e.rep = evt_repeat; e.cnt = press_cnt; e.shf = shift; e.hv = held_valid;
            e.hs = held_scan; e.ha = held_ascii; e.cyc = cycle;
            evq.push_back(e);
        end
        prev_valid = evt_valid;
        rx_ready = (fifo.size() != 0);
        rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic feed(input logic [7:0] b);
        fifo.push_back(b);
        rx_ready = 1'b1;
        rx_data  = fifo[0];
    endtask

    task automatic drain();
        int guard = 0;
        while (fifo.size() != 0 && guard < 5000) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        check("drain_done", fifo.size(), 0);
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        rx_ready = 1'b0;
        rx_data = 8'h00;
        fifo.delete();
        tick();
        tick();
        check("rst_next_n", rx_next_n, 1);
        check("rst_lk_scan", lk_scan, 0);
        check("rst_evt", {evt_valid, evt_make, evt_ext, evt_repeat}, 0);
        check("rst_evt_scan", {evt_scan, evt_ascii}, 0);
        check("rst_held", {held_valid, held_scan, held_ascii}, 0);
        check("rst_shift", shift, 0);
        check("rst_cnt", press_cnt, 0);
        clrn = 1'b1;
        tick();
        evq.delete();
        pops = 0;
    endtask

    initial begin
        // Basic make with cycle-exact latency, then a break.
        do_reset();
        feed(8'h1C);
        tick();
        check("n1_next_n", rx_next_n, 0);
        check("n1_lk_scan", lk_scan, 8'h1C);
        check("n1_no_evt", evt_valid, 0);
        tick();
        check("n2_valid", evt_valid, 1);
        check("n2_scan", evt_scan, 8'h1C);
        check("n2_ascii", evt_ascii, 8'd97);
        check("n2_make", {evt_make, evt_ext, evt_repeat}, 3'b100);
        check("n2_cnt", press_cnt, 1);
        check("n2_held", {held_valid, held_scan, held_ascii}, {1'b1, 8'h1C, 8'd97});
        tick();
        check("n3_strobe_off", evt_valid, 0);
        check("n3_fields_hold", evt_scan, 8'h1C);
        evq.delete();
        feed(8'hF0); feed(8'h1C);
        drain();
        check("brk_count", evq.size(), 1);
        if (evq.size() == 1) begin
            check("brk_fields", {evq[0].scan, evq[0].ascii, evq[0].make}, {8'h1C, 8'd97, 1'b0});
            check("brk_held", {evq[0].hv, evq[0].hs, evq[0].ha}, 0);
            check("brk_cnt", evq[0].cnt, 1);
        end

        // Shift handling and held_ascii latched at make time.
        evq.delete();
        feed(8'h12); feed(8'h1C);
        drain();
        check("sh_count", evq.size(), 2);
        if (evq.size() == 2) begin
            check("sh_make12", {evq[0].scan, evq[0].make, evq[0].shf}, {8'h12, 1'b1, 1'b1});
            check("sh_upper", evq[1].ascii, 8'd65);
            check("sh_cnt", evq[1].cnt, 3);
        end
        evq.delete();
        feed(8'hF0); feed(8'h12); feed(8'h16);
        drain();
        check("unsh_count", evq.size(), 2);
        if (evq.size() == 2) begin
            check("unsh_brk", {evq[0].scan, evq[0].make, evq[0].shf}, {8'h12, 1'b0, 1'b0});
            check("held_latched", {evq[0].hs, evq[0].ha}, {8'h1C, 8'd65});
            check("digit", {evq[1].ascii, evq[1].shf}, {8'd49, 1'b0});
            check("digit_cnt", evq[1].cnt, 4);
        end

        // Typematic repeat, back-to-back at one byte per two cycles.
        do_reset();
        feed(8'h1C); feed(8'h1C); feed(8'h1C);
        drain();
        check("rep_count", evq.size(), 3);
        check("rep_pops", pops, 3);
        check("rep_cnt", press_cnt, 1);
        if (evq.size() == 3) begin
            check("rep_flags", {evq[0].rep, evq[1].rep, evq[2].rep}, 3'b011);
            check("rep_gap1", evq[1].cyc - evq[0].cyc, 2);
            check("rep_gap2", evq[2].cyc - evq[1].cyc, 2);
        end

        // Extended prefix, E0 F0 break, and a doubled F0.
        do_reset();
        feed(8'hE0); feed(8'h12);
        drain();
        check("ext_count", evq.size(), 1);
        if (evq.size() == 1)
            check("ext_fields", {evq[0].ext, evq[0].make, evq[0].shf}, 3'b110);
        evq.delete();
        feed(8'hE0); feed(8'hF0); feed(8'h75);
        feed(8'hF0); feed(8'hF0); feed(8'h16);
        drain();
        check("ebrk_count", evq.size(), 2);
        if (evq.size() == 2) begin
            check("ebrk_fields", {evq[0].scan, evq[0].ext, evq[0].make}, {8'h75, 1'b1, 1'b0});
            check("dblf0", {evq[1].scan, evq[1].ext, evq[1].make}, {8'h16, 1'b0, 1'b0});
            check("ebrk_held", {evq[1].hv, evq[1].hs}, {1'b1, 8'h12});
        end

        // Reset after a consumed F0 discards the prefix.
        do_reset();
        feed(8'hF0);
        tick(); tick(); tick();
        do_reset();
        feed(8'h1C);
        drain();
        check("rstmid_count", evq.size(), 1);
        if (evq.size() == 1) check("rstmid_make", evq[0].make, 1);

        // 255 press/release pairs streamed continuously, then one press wraps the count.
        do_reset();
        for (int i = 0; i < 255; i++) begin
            feed((i % 2 == 0) ? 8'h1C : 8'h32);
            feed(8'hF0);
            feed((i % 2 == 0) ? 8'h1C : 8'h32);
        end
        drain();
        check("pre_cnt", press_cnt, 255);
        check("pre_evts", evq.size(), 510);
        check("pre_pops", pops, 765);
        if (evq.size() == 510) check("pre_span", evq[509].cyc - evq[0].cyc, 1528);
        feed(8'h1C);
        drain();
        check("wrap_cnt", press_cnt, 0);
        check("wrap_held", {held_valid, held_scan}, {1'b1, 8'h1C});
        check("strobe_1cyc", dbl, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
